// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - class codes, opcode constants, NOP pair and issue states for alu_issue
package alu_pkg;

  // instruction classes carried on sorf
  localparam logic [1:0] SORF_IMM  = 2'b00;
  localparam logic [1:0] SORF_SPEC = 2'b01;
  localparam logic [1:0] SORF_FPU  = 2'b10;

  // class 00: opcode field
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BLEZ = 6'b000110;
  localparam logic [5:0] OP_BGTZ = 6'b000111;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI  = 6'b001111;

  // class 01: function field
  localparam logic [5:0] FUNC_SLL  = 6'b000000;
  localparam logic [5:0] FUNC_SRL  = 6'b000010;
  localparam logic [5:0] FUNC_SRA  = 6'b000011;
  localparam logic [5:0] FUNC_JR   = 6'b001000;
  localparam logic [5:0] FUNC_ADD  = 6'b100000;
  localparam logic [5:0] FUNC_ADDU = 6'b100001;
  localparam logic [5:0] FUNC_SUB  = 6'b100010;
  localparam logic [5:0] FUNC_SUBU = 6'b100011;
  localparam logic [5:0] FUNC_AND  = 6'b100100;
  localparam logic [5:0] FUNC_OR   = 6'b100101;
  localparam logic [5:0] FUNC_XOR  = 6'b100110;
  localparam logic [5:0] FUNC_NOR  = 6'b100111;
  localparam logic [5:0] FUNC_SLT  = 6'b101010;
  localparam logic [5:0] FUNC_SLTU = 6'b101011;

  // class 10: FPU function field
  localparam logic [5:0] FPU_ADD  = 6'b000000;
  localparam logic [5:0] FPU_SUB  = 6'b000001;
  localparam logic [5:0] FPU_MUL  = 6'b000010;
  localparam logic [5:0] FPU_SQRT = 6'b000100;
  localparam logic [5:0] FPU_ABS  = 6'b000101;
  localparam logic [5:0] FPU_MOV  = 6'b000110;
  localparam logic [5:0] FPU_NEG  = 6'b000111;

  // pair driven to the execution unit whenever nothing is executing
  localparam logic [1:0] NOP_SORF = 2'b00;
  localparam logic [5:0] NOP_OP   = 6'b000000;

  // issue sequencer states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_CAPT = 2'd2;

endpackage

// File: rtl/alu_lat_decode.sv
// rtl/alu_lat_decode.sv - maps (sorf, op) to latency class, register-write and branch flags
module alu_lat_decode
  import alu_pkg::*;
(
  input  logic [1:0] sorf,
  input  logic [5:0] op,
  output logic       lat_multi,
  output logic       writes_reg,
  output logic       is_branch
);

  // table lookup; anything not listed is a single-cycle op with no side effect
  always_comb begin
    lat_multi  = 1'b0;
    writes_reg = 1'b0;
    is_branch  = 1'b0;
    case (sorf)
      SORF_IMM: begin
        case (op)
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LUI: writes_reg = 1'b1;
          OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ:                   is_branch  = 1'b1;
          default: ;
        endcase
      end
      SORF_SPEC: begin
        case (op)
          FUNC_SLL, FUNC_SRL, FUNC_SRA, FUNC_ADD, FUNC_ADDU, FUNC_SUB, FUNC_SUBU,
          FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_NOR, FUNC_SLT, FUNC_SLTU: writes_reg = 1'b1;
          default: ;
        endcase
      end
      SORF_FPU: begin
        case (op)
          FPU_ADD, FPU_SUB, FPU_MUL, FPU_SQRT: begin
            writes_reg = 1'b1;
            lat_multi  = 1'b1;
          end
          FPU_ABS, FPU_MOV, FPU_NEG: writes_reg = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - single-issue ALU/FPU sequencer; ALU_ISSUE_PERF_EN adds perf counters
module alu_issue
  import alu_pkg::*;
#(
  parameter int INST_SIZE = 10,
  parameter int MULTI_LAT = 3
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_sorf,
  input  logic [5:0]           in_op,
  input  logic [4:0]           in_rd,
  input  logic [31:0]          in_s,
  input  logic [31:0]          in_t,
  input  logic [31:0]          in_imm,
  input  logic [INST_SIZE-1:0] in_pc,
  output logic [1:0]           ex_sorf,
  output logic [5:0]           ex_op,
  output logic [31:0]          ex_s,
  output logic [31:0]          ex_t,
  output logic [31:0]          ex_imm,
  input  logic [31:0]          ex_d,
  output logic                 wb_valid,
  output logic [4:0]           wb_rd,
  output logic [31:0]          wb_data,
  output logic [INST_SIZE-1:0] wb_pc,
  output logic                 br_valid,
  output logic                 br_taken
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]          perf_issued,
  output logic [31:0]          perf_stall
`endif
);

  localparam logic [3:0] LAT_MULTI = 4'(MULTI_LAT);

  state_t               state;
  logic [3:0]           cnt;
  logic [3:0]           h_lat;
  logic [4:0]           h_rd;
  logic [INST_SIZE-1:0] h_pc;
  logic                 h_wr;
  logic                 h_br;
  logic                 d_multi;
  logic                 d_wr;
  logic                 d_br;

  alu_lat_decode u_dec (
    .sorf       (in_sorf),
    .op         (in_op),
    .lat_multi  (d_multi),
    .writes_reg (d_wr),
    .is_branch  (d_br)
  );

  assign in_ready = (state == ST_IDLE);

  // accept, hold operands for L cycles, then park the execution unit on NOP
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      h_lat   <= 4'd0;
      h_rd    <= 5'd0;
      h_pc    <= '0;
      h_wr    <= 1'b0;
      h_br    <= 1'b0;
      ex_sorf <= NOP_SORF;
      ex_op   <= NOP_OP;
      ex_s    <= 32'd0;
      ex_t    <= 32'd0;
      ex_imm  <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            ex_sorf <= in_sorf;
            ex_op   <= in_op;
            ex_s    <= in_s;
            ex_t    <= in_t;
            ex_imm  <= in_imm;
            h_rd    <= in_rd;
            h_pc    <= in_pc;
            h_wr    <= d_wr && (in_rd != 5'd0);
            h_br    <= d_br;
            h_lat   <= d_multi ? LAT_MULTI : 4'd1;
            cnt     <= 4'd1;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          cnt <= cnt + 4'd1;
          if (cnt == h_lat) begin
            ex_sorf <= NOP_SORF;
            ex_op   <= NOP_OP;
            state   <= ST_CAPT;
          end
        end
        ST_CAPT: begin
          cnt   <= 4'd0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // capture the execution result and emit one-cycle writeback / branch pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_valid <= 1'b0;
      wb_rd    <= 5'd0;
      wb_data  <= 32'd0;
      wb_pc    <= '0;
      br_valid <= 1'b0;
      br_taken <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      br_valid <= 1'b0;
      if (state == ST_CAPT) begin
        wb_data  <= ex_d;
        wb_rd    <= h_rd;
        wb_pc    <= h_pc;
        wb_valid <= h_wr;
        br_valid <= h_br;
        if (h_br) begin
          br_taken <= ex_d[0];
        end
      end
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  // accepted-instruction and blocked-offer counters, free-running with wrap
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_issued <= 32'd0;
      perf_stall  <= 32'd0;
    end else begin
      if (in_valid && in_ready) begin
        perf_issued <= perf_issued + 32'd1;
      end
      if (in_valid && !in_ready) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - randomized bench for alu_issue against a cycle-count reference model
module tb_alu_issue;
  import alu_pkg::*;

  localparam int IW = 10;
  localparam int ML = 3;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_sorf = '0;
  logic [5:0]    in_op = '0;
  logic [4:0]    in_rd = '0;
  logic [31:0]   in_s = '0, in_t = '0, in_imm = '0;
  logic [IW-1:0] in_pc = '0;
  logic [1:0]    ex_sorf;
  logic [5:0]    ex_op;
  logic [31:0]   ex_s, ex_t, ex_imm;
  logic [31:0]   ex_d = '0;
  logic          wb_valid;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_data;
  logic [IW-1:0] wb_pc;
  logic          br_valid, br_taken;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0]   perf_issued, perf_stall;
`endif

  alu_issue #(.INST_SIZE(IW), .MULTI_LAT(ML)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_sorf(in_sorf), .in_op(in_op), .in_rd(in_rd), .in_s(in_s), .in_t(in_t),
    .in_imm(in_imm), .in_pc(in_pc), .ex_sorf(ex_sorf), .ex_op(ex_op),
    .ex_s(ex_s), .ex_t(ex_t), .ex_imm(ex_imm), .ex_d(ex_d),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc),
    .br_valid(br_valid), .br_taken(br_taken)
`ifdef ALU_ISSUE_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // single-precision multiply for normal operands, truncating
  function automatic logic [31:0] fmul(logic [31:0] a, logic [31:0] b);
    logic [47:0] p;
    logic [7:0]  e;
    logic [22:0] m;
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    if (p[47]) begin
      m = p[46:24];
      e = a[30:23] + b[30:23] - 8'd126;
    end else begin
      m = p[45:23];
      e = a[30:23] + b[30:23] - 8'd127;
    end
    return {a[31] ^ b[31], e, m};
  endfunction

  // behavioural execution unit result
  function automatic logic [31:0] exec_fn(logic [1:0] c, logic [5:0] o,
                                          logic [31:0] s, logic [31:0] t, logic [31:0] imm);
    logic [31:0] r;
    case (c)
      2'b00: case (o)
        OP_ADDI: r = s + imm;
        OP_ANDI: r = s & imm;
        OP_ORI:  r = s | imm;
        OP_XORI: r = s ^ imm;
        OP_SLTI: r = {31'd0, $signed(s) < $signed(imm)};
        OP_LUI:  r = {imm[15:0], 16'h0};
        OP_BEQ:  r = {31'd0, s == t};
        OP_BNE:  r = {31'd0, s != t};
        OP_BLEZ: r = {31'd0, $signed(s) <= 0};
        OP_BGTZ: r = {31'd0, $signed(s) > 0};
        default: r = s ^ imm;
      endcase
      2'b01: case (o)
        FUNC_ADD, FUNC_ADDU: r = s + t;
        FUNC_SUB, FUNC_SUBU: r = s - t;
        FUNC_AND: r = s & t;
        FUNC_OR:  r = s | t;
        FUNC_XOR: r = s ^ t;
        FUNC_NOR: r = ~(s | t);
        FUNC_SLT: r = {31'd0, $signed(s) < $signed(t)};
        FUNC_SLTU: r = {31'd0, s < t};
        FUNC_SLL: r = t << imm[10:6];
        FUNC_SRL: r = t >> imm[10:6];
        FUNC_SRA: r = $signed(t) >>> imm[10:6];
        default:  r = s ^ t ^ 32'h5a5a;
      endcase
      2'b10: case (o)
        FPU_MUL: r = fmul(s, t);
        FPU_ABS: r = {1'b0, s[30:0]};
        FPU_NEG: r = {~s[31], s[30:0]};
        FPU_MOV: r = s;
        default: r = s + t + 32'(o);
      endcase
      default: r = ~s;
    endcase
    return r;
  endfunction

  always @(posedge clk) ex_d <= exec_fn(ex_sorf, ex_op, ex_s, ex_t, ex_imm);

  // reference rules
  function automatic int m_lat(logic [1:0] c, logic [5:0] o);
    return (c == 2'b10 && o inside {FPU_ADD, FPU_SUB, FPU_MUL, FPU_SQRT}) ? ML : 1;
  endfunction

  function automatic bit m_branch(logic [1:0] c, logic [5:0] o);
    return c == 2'b00 && o inside {OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ};
  endfunction

  function automatic bit m_writes(logic [1:0] c, logic [5:0] o, logic [4:0] rd);
    bit w;
    w = (c == 2'b00 && o inside {OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LUI}) ||
        (c == 2'b01 && o inside {FUNC_SLL, FUNC_SRL, FUNC_SRA, FUNC_ADD, FUNC_ADDU, FUNC_SUB,
                                 FUNC_SUBU, FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_NOR, FUNC_SLT,
                                 FUNC_SLTU}) ||
        (c == 2'b10 && o inside {FPU_ADD, FPU_SUB, FPU_MUL, FPU_SQRT, FPU_ABS, FPU_MOV, FPU_NEG});
    return w && rd != 5'd0;
  endfunction

  // model state: accept edge, latency, next free edge, held operands
  int cyc = 0, free_at = 0, acc_at = 0, lat = 1, acc_edge = 0;
  bit have = 0, acc_now = 0;
  logic [1:0] m_sorf;
  logic [5:0] m_op;
  logic [4:0] m_rd;
  logic [IW-1:0] m_pc;
  logic [31:0] m_s, m_t, m_imm;
  logic [31:0] e_s = '0, e_t = '0, e_imm = '0;
  logic [31:0] p_iss = '0, p_stall = '0;

  int wb_cnt = 0, br_cnt = 0, last_wb_edge = 0, fpu_held = 0;
  logic [31:0] last_wb_data = '0;
  logic [4:0]  last_wb_rd = '0;
  logic        last_br_taken = 1'b0;

  task automatic model_clear();
    have = 0; free_at = 0;
    e_s = '0; e_t = '0; e_imm = '0;
    p_iss = '0; p_stall = '0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_ex_sorf"}, 64'(ex_sorf), 64'd0);
    chk({tag, "_ex_op"}, 64'(ex_op), 64'd0);
    chk({tag, "_ex_s"}, 64'(ex_s), 64'd0);
    chk({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
    chk({tag, "_wb_data"}, 64'(wb_data), 64'd0);
    chk({tag, "_br_valid"}, 64'(br_valid), 64'd0);
  endtask

  // one clock: update the model on the edge, compare outputs on the falling edge
  task automatic tick();
    int k;
    bit in_exec, wb_now;
    logic [31:0] res;
    @(posedge clk);
    k = cyc;
    acc_now = 0;
    if (!rstn) begin
      model_clear();
    end else if (in_valid) begin
      if (k >= free_at) begin
        have = 1; acc_at = k; acc_edge = k; acc_now = 1;
        lat = m_lat(in_sorf, in_op);
        free_at = k + lat + 2;
        m_sorf = in_sorf; m_op = in_op; m_rd = in_rd; m_pc = in_pc;
        m_s = in_s; m_t = in_t; m_imm = in_imm;
        e_s = in_s; e_t = in_t; e_imm = in_imm;
        p_iss = p_iss + 32'd1;
      end else begin
        p_stall = p_stall + 32'd1;
      end
    end
    @(negedge clk);
    if (!rstn) begin
      chk_zero("in_reset");
    end else begin
      in_exec = have && k >= acc_at && k < acc_at + lat;
      wb_now  = have && k == acc_at + lat + 1;
      chk("in_ready", 64'(in_ready), 64'(k + 1 >= free_at));
      chk("ex_sorf", 64'(ex_sorf), in_exec ? 64'(m_sorf) : 64'd0);
      chk("ex_op", 64'(ex_op), in_exec ? 64'(m_op) : 64'd0);
      chk("ex_s", 64'(ex_s), 64'(e_s));
      chk("ex_t", 64'(ex_t), 64'(e_t));
      chk("ex_imm", 64'(ex_imm), 64'(e_imm));
      chk("wb_valid", 64'(wb_valid), 64'(wb_now && m_writes(m_sorf, m_op, m_rd)));
      chk("br_valid", 64'(br_valid), 64'(wb_now && m_branch(m_sorf, m_op)));
      if (wb_now) begin
        res = exec_fn(m_sorf, m_op, m_s, m_t, m_imm);
        chk("wb_data", 64'(wb_data), 64'(res));
        chk("wb_rd", 64'(wb_rd), 64'(m_rd));
        chk("wb_pc", 64'(wb_pc), 64'(m_pc));
        if (m_branch(m_sorf, m_op)) chk("br_taken", 64'(br_taken), 64'(res[0]));
      end
`ifdef ALU_ISSUE_PERF_EN
      chk("perf_issued", 64'(perf_issued), 64'(p_iss));
      chk("perf_stall", 64'(perf_stall), 64'(p_stall));
`endif
    end
    if (wb_valid) begin
      wb_cnt++; last_wb_edge = k; last_wb_data = wb_data; last_wb_rd = wb_rd;
    end
    if (br_valid) begin
      br_cnt++; last_br_taken = br_taken;
    end
    if (ex_sorf == 2'b10) fpu_held++;
    cyc++;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // present an instruction and hold it until the model says it was accepted
  task automatic offer(logic [1:0] c, logic [5:0] o, logic [4:0] rd,
                       logic [31:0] s, logic [31:0] t, logic [31:0] imm, bit keep);
    in_valid = 1'b1;
    in_sorf = c; in_op = o; in_rd = rd; in_s = s; in_t = t; in_imm = imm;
    in_pc = IW'($urandom);
    acc_now = 0;
    for (int i = 0; i < 40 && !acc_now; i++) tick();
    if (!acc_now) chk("accept_timeout", 64'd0, 64'd1);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk_zero("async_rst");
    model_clear();
    run(2);
    rstn = 1'b1;
  endtask

  logic [5:0] tab0 [10] = '{OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LUI,
                            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ};
  logic [5:0] tab1 [14] = '{FUNC_SLL, FUNC_SRL, FUNC_SRA, FUNC_JR, FUNC_ADD, FUNC_ADDU,
                            FUNC_SUB, FUNC_SUBU, FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_NOR,
                            FUNC_SLT, FUNC_SLTU};
  logic [5:0] tab2 [7]  = '{FPU_ADD, FPU_SUB, FPU_MUL, FPU_SQRT, FPU_ABS, FPU_MOV, FPU_NEG};

  initial begin
    int a1, a2, w0, b0;
    logic [1:0] c;
    logic [5:0] o;

    run(2);
    rstn = 1'b1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk_zero("rst_state");
    run(1);

    // ADDI 5+7 -> r3
    offer(2'b00, OP_ADDI, 5'd3, 32'd5, 32'd0, 32'd7, 1'b0);
    a1 = acc_edge;
    run(4);
    chk("addi_latency", 64'(last_wb_edge + 1 - a1), 64'd3);
    chk("addi_wb_data", 64'(last_wb_data), 64'd12);
    chk("addi_wb_rd", 64'(last_wb_rd), 64'd3);

    // FPU mul 2.0*3.0
    fpu_held = 0;
    offer(2'b10, FPU_MUL, 5'd7, 32'h40000000, 32'h40400000, 32'd0, 1'b0);
    a1 = acc_edge;
    run(6);
    chk("mul_ex_held", 64'(fpu_held), 64'd3);
    chk("mul_latency", 64'(last_wb_edge + 1 - a1), 64'd5);
    chk("mul_wb_data", 64'(last_wb_data), 64'h40C00000);

    // BEQ taken / not taken
    w0 = wb_cnt; b0 = br_cnt;
    offer(2'b00, OP_BEQ, 5'd4, 32'd9, 32'd9, 32'd0, 1'b0);
    run(4);
    chk("beq_br_pulse", 64'(br_cnt - b0), 64'd1);
    chk("beq_taken", 64'(last_br_taken), 64'd1);
    offer(2'b00, OP_BEQ, 5'd4, 32'd9, 32'd8, 32'd0, 1'b0);
    run(4);
    chk("bne_br_pulse", 64'(br_cnt - b0), 64'd2);
    chk("beq_not_taken", 64'(last_br_taken), 64'd0);
    chk("beq_no_wb", 64'(wb_cnt - w0), 64'd0);

    // ADD to r0 then JR back to back
    w0 = wb_cnt;
    offer(2'b01, FUNC_ADD, 5'd0, 32'd1, 32'd2, 32'd0, 1'b1);
    a1 = acc_edge;
    offer(2'b01, FUNC_JR, 5'd4, 32'd3, 32'd0, 32'd0, 1'b0);
    a2 = acc_edge;
    run(4);
    chk("b2b_issue_gap", 64'(a2 - a1), 64'd3);
    chk("rd0_jr_no_wb", 64'(wb_cnt - w0), 64'd0);

    // reset during sqrt EXEC
    offer(2'b10, FPU_SQRT, 5'd9, 32'h40800000, 32'd0, 32'd0, 1'b0);
    run(1);
    do_reset();
    w0 = wb_cnt; b0 = br_cnt;
    run(6);
    chk("rst_no_wb", 64'(wb_cnt - w0), 64'd0);
    chk("rst_no_br", 64'(br_cnt - b0), 64'd0);
    offer(2'b00, OP_ADDI, 5'd6, 32'd1, 32'd0, 32'd2, 1'b0);
    run(4);
    chk("post_rst_addi_data", 64'(last_wb_data), 64'd3);
    chk("post_rst_addi_rd", 64'(last_wb_rd), 64'd6);

`ifdef ALU_ISSUE_PERF_EN
    do_reset();
    offer(2'b00, OP_ADDI, 5'd1, 32'd1, 32'd0, 32'd1, 1'b1);
    offer(2'b00, OP_ORI, 5'd2, 32'd1, 32'd0, 32'd2, 1'b0);
    run(3);
    chk("perf_issued_2", 64'(perf_issued), 64'd2);
    chk("perf_stall_2", 64'(perf_stall), 64'd2);
`endif

    // random traffic, including out-of-table ops and class 11
    for (int n = 0; n < 150; n++) begin
      c = 2'($urandom_range(0, 3));
      case (c)
        2'b00:   o = tab0[$urandom_range(0, 9)];
        2'b01:   o = tab1[$urandom_range(0, 13)];
        2'b10:   o = tab2[$urandom_range(0, 6)];
        default: o = 6'($urandom);
      endcase
      if ($urandom_range(0, 4) == 0) o = 6'($urandom);
      offer(c, o, 5'($urandom), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
      if (!in_valid) run($urandom_range(0, 3));
    end
    in_valid = 1'b0;
    run(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
